// File: rtl/gshare_pkg.sv
// gshare_pkg: definitions shared by the branch resolve unit and its queue.
//   - br_state_e : recovery FSM states (IDLE, RECOVER, HOLD)
//   - CTR_*      : 2-bit saturating counter constants
//   - br_entry_t : one in-flight prediction. The fields are sized to generous
//                  maxima, so one struct serves any ADDRESS_WIDTH <= 64 and
//                  GHR_SIZE <= 32. Unused upper bits are held at zero.
//   - ctr_train  : saturating counter update
package gshare_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    HOLD    = 2'd2
  } br_state_e;

  localparam logic [1:0] CTR_MAX        = 2'd3;
  localparam logic [1:0] CTR_MIN        = 2'd0;
  localparam logic [1:0] CTR_WEAK_TAKEN = 2'd2;

  localparam int ENTRY_ADDR_W = 64;
  localparam int ENTRY_GHR_W  = 32;

  typedef struct packed {
    logic                    taken;
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_ADDR_W-1:0] target;
    logic [ENTRY_GHR_W-1:0]  index;
    logic [1:0]              counter;
    logic [ENTRY_GHR_W-1:0]  ghr;
  } br_entry_t;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// branch_queue: synchronous FIFO holding the in-flight branch predictions.
// Ports:
//   i_Clk, i_Reset      clock, synchronous active-high reset
//   i_Push / i_Data     write one entry (ignored when full)
//   i_Pop               drop the head entry (ignored when empty)
//   i_Clear             empty the queue; takes priority over push and pop
//   o_Data              head entry (valid when !o_Empty)
//   o_Full, o_Empty     status
//   o_Count             current occupancy, 0..DEPTH
// The pointers carry one extra bit so that full and empty can be told apart.
module branch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Push,
  input  logic                       i_Pop,
  input  logic                       i_Clear,
  input  logic [WIDTH-1:0]           i_Data,
  output logic [WIDTH-1:0]           o_Data,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH):0]     o_Count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic                         push_ok, pop_ok;

  always_comb begin
    o_Empty = (wr_ptr_q == rd_ptr_q);
    o_Full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    o_Count = wr_ptr_q - rd_ptr_q;
    o_Data  = mem_q[rd_ptr_q[PW-1:0]];
    push_ok = i_Push && !o_Full;
    pop_ok  = i_Pop && !o_Empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (i_Clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q[PW-1:0]] = i_Data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries behind a valid pointer are read.
  always_ff @(posedge i_Clk) mem_q <= mem_d;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pairs gshare predictions with ALU outcomes, trains the
// 2-bit counter table and recovers fetch on a mispredict.
// Ports:
//   i_Clk, i_Reset            clock, synchronous active-high reset
//   i_Stall                   gates prediction enqueue and resolve acceptance
//   i_Pred_*, o_Pred_ready    prediction capture from fetch
//   i_Resolve_*               outcome of the oldest in-flight branch
//   o_Train_*                 counter write-back (one-cycle pulse)
//   o_Flush, o_Redirect(_pc)  mispredict recovery (one-cycle pulse)
//   o_Ghr_restore(_we)        corrected global history
//   o_Resolve_error           resolve seen with nothing in flight
//   o_Stat_*                  branch / mispredict counters
// Build option: define BRANCH_STATS_EN to generate the statistics counters.
// Without it the o_Stat_* ports are tied to zero.
module branch_resolve_unit
  import gshare_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22,
  parameter int GHR_SIZE      = 8,
  parameter int DEPTH         = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Stall,
  input  logic                     i_Pred_valid,
  input  logic                     i_Pred_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_Pred_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_Pred_target,
  input  logic [GHR_SIZE-1:0]      i_Pred_index,
  input  logic [1:0]               i_Pred_counter,
  input  logic [GHR_SIZE-1:0]      i_Pred_ghr,
  output logic                     o_Pred_ready,
  input  logic                     i_Resolve_valid,
  input  logic                     i_Resolve_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_Resolve_target,
  output logic                     o_Train_we,
  output logic [GHR_SIZE-1:0]      o_Train_index,
  output logic [1:0]               o_Train_counter,
  output logic                     o_Flush,
  output logic                     o_Redirect,
  output logic [ADDRESS_WIDTH-1:0] o_Redirect_pc,
  output logic                     o_Ghr_restore_we,
  output logic [GHR_SIZE-1:0]      o_Ghr_restore,
  output logic                     o_Resolve_error,
  output logic [31:0]              o_Stat_branches,
  output logic [31:0]              o_Stat_mispredicts
);
  localparam int DW = $clog2(DEPTH);

  br_state_e state_q, state_d;
  br_entry_t push_data, head;
  logic      q_full, q_empty;
  logic [DW:0] occ, occ_next;
  logic      in_idle, enq, res, hit, mispredict, push, clear;
  logic [ADDRESS_WIDTH-1:0] head_pc, head_target;
  logic [GHR_SIZE-1:0]      head_index, head_ghr;

  logic                     ready_q, ready_d;
  logic                     train_we_q, train_we_d;
  logic [GHR_SIZE-1:0]      train_index_q, train_index_d;
  logic [1:0]               train_ctr_q, train_ctr_d;
  logic                     recover_q, recover_d;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [GHR_SIZE-1:0]      ghr_q, ghr_d;
  logic                     error_q, error_d;

  // Entries are wider than needed; fold the whole head into one bit so the
  // unused upper bits are consumed.
  logic unused_head_bits;
  assign unused_head_bits = ^head;

  branch_queue #(.WIDTH($bits(br_entry_t)), .DEPTH(DEPTH)) u_queue (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Push  (push),
    .i_Pop   (hit),
    .i_Clear (clear),
    .i_Data  (push_data),
    .o_Data  (head),
    .o_Full  (q_full),
    .o_Empty (q_empty),
    .o_Count (occ)
  );

  always_comb begin
    push_data         = '0;
    push_data.taken   = i_Pred_taken;
    push_data.pc      = ENTRY_ADDR_W'(i_Pred_pc);
    push_data.target  = ENTRY_ADDR_W'(i_Pred_target);
    push_data.index   = ENTRY_GHR_W'(i_Pred_index);
    push_data.counter = i_Pred_counter;
    push_data.ghr     = ENTRY_GHR_W'(i_Pred_ghr);

    head_pc     = ADDRESS_WIDTH'(head.pc);
    head_target = ADDRESS_WIDTH'(head.target);
    head_index  = GHR_SIZE'(head.index);
    head_ghr    = GHR_SIZE'(head.ghr);

    in_idle = (state_q == IDLE);
    enq     = i_Pred_valid && ready_q && !i_Stall;
    res     = i_Resolve_valid && !i_Stall && in_idle;
    hit     = res && !q_empty;
    // A taken/taken pair still mispredicts when the targets disagree.
    mispredict = hit && ((head.taken != i_Resolve_taken) ||
                         (head.taken && i_Resolve_taken && (i_Resolve_target != head_target)));
    // Whatever fetch sends alongside a mispredicting resolve is wrong-path.
    push  = enq && !mispredict;
    clear = (state_q == RECOVER);

    case (state_q)
      IDLE:    state_d = mispredict ? RECOVER : IDLE;
      RECOVER: state_d = HOLD;
      default: state_d = IDLE;
    endcase

    // Ready is registered, so it is derived from next-cycle occupancy/state.
    occ_next = clear ? '0 : occ + {{DW{1'b0}}, push} - {{DW{1'b0}}, hit};
    ready_d  = (state_d == IDLE) && (occ_next != (DW+1)'(DEPTH));

    train_we_d    = hit;
    train_index_d = hit ? head_index : '0;
    train_ctr_d   = hit ? ctr_train(head.counter, i_Resolve_taken) : 2'd0;
    recover_d     = mispredict;
    redirect_pc_d = '0;
    ghr_d         = '0;
    if (mispredict) begin
      redirect_pc_d = i_Resolve_taken ? i_Resolve_target : head_pc + ADDRESS_WIDTH'(1);
      ghr_d         = {head_ghr[GHR_SIZE-2:0], i_Resolve_taken};
    end
    error_d = res && q_empty;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      train_we_q    <= 1'b0;
      train_index_q <= '0;
      train_ctr_q   <= 2'd0;
      recover_q     <= 1'b0;
      redirect_pc_q <= '0;
      ghr_q         <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      train_we_q    <= train_we_d;
      train_index_q <= train_index_d;
      train_ctr_q   <= train_ctr_d;
      recover_q     <= recover_d;
      redirect_pc_q <= redirect_pc_d;
      ghr_q         <= ghr_d;
      error_q       <= error_d;
    end
  end

  assign o_Pred_ready     = ready_q;
  assign o_Train_we       = train_we_q;
  assign o_Train_index    = train_index_q;
  assign o_Train_counter  = train_ctr_q;
  // The cycle after a mispredict is the RECOVER cycle: flush, redirect and
  // GHR restore all fire together.
  assign o_Flush          = recover_q;
  assign o_Redirect       = recover_q;
  assign o_Ghr_restore_we = recover_q;
  assign o_Redirect_pc    = redirect_pc_q;
  assign o_Ghr_restore    = ghr_q;
  assign o_Resolve_error  = error_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q + {31'd0, hit};
    stat_mp_d = stat_mp_q + {31'd0, mispredict};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign o_Stat_branches    = stat_br_q;
  assign o_Stat_mispredicts = stat_mp_q;
`else
  assign o_Stat_branches    = '0;
  assign o_Stat_mispredicts = '0;
`endif

endmodule
